// File: rtl/rr_stream_mux.sv
// ---------------------------------------------------------------------------
// rr_stream_mux
// N-to-1 valid/ready stream merger with round-robin arbitration and a single
// registered output stage. The output carries the source channel index on
// out_sel so a downstream select-driven demux can route the word back out.
//
// Parameters:
//   SW  select width, N_CH = 2**SW channels (SW in 1..3)
//   DW  data width per channel
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel valid (N_CH)
//   in_data    channel k data in bits [k*DW +: DW]
//   in_ready   per-channel accept, one-hot or zero
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_sel    channel index that sourced out_data
//   out_ready  downstream accept
//   in_last    (RR_MUX_PKT_LOCK_EN only) per-channel end-of-packet flag
//   out_last   (RR_MUX_PKT_LOCK_EN only) registered end-of-packet flag
//
// Optional feature macro: RR_MUX_PKT_LOCK_EN
//   When defined, a channel that starts a packet keeps the grant until its
//   beat with in_last set has been transferred.
// ---------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int SW = 1,
  parameter int DW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [(1<<SW)-1:0]       in_valid,
  input  logic [(1<<SW)*DW-1:0]    in_data,
  output logic [(1<<SW)-1:0]       in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [(1<<SW)-1:0]       in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  output logic [SW-1:0]            out_sel,
  input  logic                     out_ready
);

  localparam int N_CH = 1 << SW;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] last_grant_q, last_grant_d;
`ifdef RR_MUX_PKT_LOCK_EN
  logic          lock_q, lock_d;
  logic          olast_q, olast_d;
`endif

  logic          found;
  logic [SW-1:0] win;
  logic [SW-1:0] cand;
  logic          load;
  logic          grant;

  // Round-robin search starting one past the last granted channel. SW-bit
  // addition wraps modulo N_CH on its own; the final step revisits
  // last_grant itself so a lone requester can be granted back to back.
  // While a packet lock is held, only the locked channel may win.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = last_grant_q + SW'(i);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`ifdef RR_MUX_PKT_LOCK_EN
    if (lock_q) begin
      found = in_valid[last_grant_q];
      win   = last_grant_q;
    end
`endif
  end

  // The output register can take a word when empty or being drained this
  // cycle. Reset suppresses grants so nothing is accepted and then dropped.
  assign load     = (state_q == EMPTY) | out_ready;
  assign grant    = found & load & !rst;
  assign in_ready = grant ? (N_CH'(1) << win) : '0;

  // Next-state logic: a grant always (re)fills the register, even while it
  // is being drained, which sustains one word per cycle. A drain with no
  // grant only clears valid; data and select keep their last values.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
`ifdef RR_MUX_PKT_LOCK_EN
    lock_d       = lock_q;
    olast_d      = olast_q;
`endif
    if (grant) begin
      state_d      = FULL;
      data_d       = in_data[win*DW +: DW];
      sel_d        = win;
      last_grant_d = win;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_d       = !in_last[win];
      olast_d      = in_last[win];
`endif
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  // State and output registers with synchronous reset; reset discards any
  // held word and points last_grant at N_CH-1 so channel 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      sel_q        <= '0;
      last_grant_q <= SW'(N_CH - 1);
`ifdef RR_MUX_PKT_LOCK_EN
      lock_q       <= 1'b0;
      olast_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
`ifdef RR_MUX_PKT_LOCK_EN
      lock_q       <= lock_d;
      olast_q      <= olast_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
`ifdef RR_MUX_PKT_LOCK_EN
  assign out_last  = olast_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_stream_mux
// Directed bench for rr_stream_mux with SW=1, DW=8. Each scenario task drives
// inputs a little after the rising edge and checks registered outputs one
// time unit after the edge; combinational in_ready is checked after the
// inputs have settled. Packet-lock scenario runs when RR_MUX_PKT_LOCK_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_rr_stream_mux;

  logic        clk;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_sel;
  logic        out_ready;
`ifdef RR_MUX_PKT_LOCK_EN
  logic [1:0]  in_last;
  logic        out_last;
`endif

  int testCount = 0;
  int failCount = 0;

  rr_stream_mux #(.SW(1), .DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held two cycles with both channels requesting, then first word
  task automatic test_reset();
    rst = 1'b1; in_valid = 2'b11; in_data = 16'h2211; out_ready = 1'b1;
    tick(); tick();
    testCount++;
    if (in_ready !== 2'b00) begin
      $display("[TB] FAIL reset_in_ready got %b want 00", in_ready); failCount++;
    end
    testCount++;
    if (out_valid !== 1'b0 || out_sel !== 1'b0 || out_data !== 8'h00) begin
      $display("[TB] FAIL reset_outputs got v=%b s=%b d=%h want v=0 s=0 d=00",
               out_valid, out_sel, out_data); failCount++;
    end
    rst = 1'b0;
    #1;
    testCount++;
    if (in_ready !== 2'b01) begin
      $display("[TB] FAIL reset_first_ready got %b want 01", in_ready); failCount++;
    end
    tick();
    testCount++;
    if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'h11) begin
      $display("[TB] FAIL reset_first_word got v=%b s=%b d=%h want v=1 s=0 d=11",
               out_valid, out_sel, out_data); failCount++;
    end
    in_valid = 2'b00;
    tick();
  endtask

  // Only channel 1 requests; then a drain with no new grant
  task automatic test_single_source();
    in_valid = 2'b10; in_data = 16'hA500; out_ready = 1'b1;
    #1;
    testCount++;
    if (in_ready !== 2'b10) begin
      $display("[TB] FAIL single_ready got %b want 10", in_ready); failCount++;
    end
    tick();
    in_valid = 2'b00;
    testCount++;
    if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'hA5) begin
      $display("[TB] FAIL single_word got v=%b s=%b d=%h want v=1 s=1 d=A5",
               out_valid, out_sel, out_data); failCount++;
    end
    tick();
    testCount++;
    if (out_valid !== 1'b0 || out_sel !== 1'b1 || out_data !== 8'hA5) begin
      $display("[TB] FAIL drain_hold got v=%b s=%b d=%h want v=0 s=1 d=A5",
               out_valid, out_sel, out_data); failCount++;
    end
  endtask

  // Both channels continuously valid: alternating grants, no bubbles
  task automatic test_round_robin();
    logic [0:0] expSel;
    logic [7:0] expData;
    in_valid = 2'b11; in_data = 16'h2211; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expSel  = 1'(i % 2);
      expData = (i % 2 == 0) ? 8'h11 : 8'h22;
      tick();
      testCount++;
      if (out_valid !== 1'b1 || out_sel !== expSel || out_data !== expData) begin
        $display("[TB] FAIL rr_word%0d got v=%b s=%b d=%h want v=1 s=%b d=%h",
                 i, out_valid, out_sel, out_data, expSel, expData); failCount++;
      end
    end
  endtask

  // Hold 22/sel1 under backpressure, then release loads channel 0
  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      testCount++;
      if (in_ready !== 2'b00) begin
        $display("[TB] FAIL bp_ready%0d got %b want 00", i, in_ready); failCount++;
      end
      tick();
      testCount++;
      if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'h22) begin
        $display("[TB] FAIL bp_hold%0d got v=%b s=%b d=%h want v=1 s=1 d=22",
                 i, out_valid, out_sel, out_data); failCount++;
      end
    end
    out_ready = 1'b1;
    #1;
    testCount++;
    if (in_ready !== 2'b01) begin
      $display("[TB] FAIL bp_release_ready got %b want 01", in_ready); failCount++;
    end
    tick();
    testCount++;
    if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'h11) begin
      $display("[TB] FAIL bp_release_word got v=%b s=%b d=%h want v=1 s=0 d=11",
               out_valid, out_sel, out_data); failCount++;
    end
  endtask

  // Reset while FULL discards the word and restores channel-0 priority
  task automatic test_reset_mid();
    tick();
    testCount++;
    if (out_sel !== 1'b1 || out_data !== 8'h22) begin
      $display("[TB] FAIL mid_pre got s=%b d=%h want s=1 d=22", out_sel, out_data);
      failCount++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    testCount++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 1'b0) begin
      $display("[TB] FAIL mid_reset got v=%b s=%b d=%h want v=0 s=0 d=00",
               out_valid, out_sel, out_data); failCount++;
    end
    tick();
    testCount++;
    if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'h11) begin
      $display("[TB] FAIL mid_first got v=%b s=%b d=%h want v=1 s=0 d=11",
               out_valid, out_sel, out_data); failCount++;
    end
    // last grant is now channel 0; reset under backpressure must still
    // hand priority back to channel 0 rather than channel 1
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    testCount++;
    if (in_ready !== 2'b01) begin
      $display("[TB] FAIL mid_prio_ready got %b want 01", in_ready); failCount++;
    end
    tick();
    testCount++;
    if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'h11) begin
      $display("[TB] FAIL mid_prio_word got v=%b s=%b d=%h want v=1 s=0 d=11",
               out_valid, out_sel, out_data); failCount++;
    end
    in_valid = 2'b00;
    tick();
  endtask

`ifdef RR_MUX_PKT_LOCK_EN
  // Channel 0 sends a 3-beat packet while channel 1 requests throughout
  task automatic test_pkt_lock();
    logic [0:0] expSel [4];
    logic       expLast [3];
    expSel[0] = 1'b0; expSel[1] = 1'b0; expSel[2] = 1'b0; expSel[3] = 1'b1;
    expLast[0] = 1'b0; expLast[1] = 1'b0; expLast[2] = 1'b1;
    // single-beat packet on channel 1 so channel 0 is next in the rotation
    in_valid = 2'b10; in_last = 2'b10; in_data = 16'h2211; out_ready = 1'b1;
    tick();
    in_valid = 2'b11; in_last = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2) ? 2'b01 : 2'b00;
      tick();
      testCount++;
      if (out_valid !== 1'b1 || out_sel !== expSel[i]) begin
        $display("[TB] FAIL lock_sel%0d got v=%b s=%b want v=1 s=%b",
                 i, out_valid, out_sel, expSel[i]); failCount++;
      end
      if (i < 3) begin
        testCount++;
        if (out_last !== expLast[i]) begin
          $display("[TB] FAIL lock_last%0d got %b want %b", i, out_last, expLast[i]);
          failCount++;
        end
      end
    end
    in_valid = 2'b00; in_last = 2'b00;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 2'b00; in_data = 16'h0000; out_ready = 1'b0;
`ifdef RR_MUX_PKT_LOCK_EN
    in_last = 2'b00;
`endif
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef RR_MUX_PKT_LOCK_EN
    test_pkt_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
